reg_bank_write_arbiter: RTL
===========================

// Module: reg_bank_write_arbiter
// PURPOSE
//   Round-robin write arbiter and sequencer for a small bank of DATA_WIDTH-bit
//   enable-gated registers (async active-low clear, load on write enable).
//   Multiple requesters share one write path into the bank.
//   Requests are accepted one at a time, the load is sequenced, and a one-cycle grant is returned.
//   A combinational read port exposes any register to the rest of the datapath.
// PARAMETERS
//   NUM_REQ     4   number of write requesters (2..8)
//   DATA_WIDTH  3   width of each bank register
//   ADDR_WIDTH  2   register address width; bank depth NUM_REGS = 2**ADDR_WIDTH
// PORTS
//   clock       in   1                     rising-edge clock
//   reset       in   1                     asynchronous, active-low reset
//   req         in   NUM_REQ               per-requester write request, level, held until grant
//   req_addr    in   NUM_REQ*ADDR_WIDTH    packed target address, slice i = requester i
//   req_data    in   NUM_REQ*DATA_WIDTH    packed write data, slice i = requester i
//   grant       out  NUM_REQ               one-hot, single-cycle; write of requester i committed
//   busy        out  1                     high while in WRITE state
//   contended   out  1                     high in WRITE if >1 req was pending at arbitration
//   rd_addr     in   ADDR_WIDTH            read address
//   rd_data     out  DATA_WIDTH            bank[rd_addr], combinational
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE; grant=0; busy=0; contended=0.
//     All bank registers = 0; rr pointer last=NUM_REQ-1, so requester 0 has top priority first.
//   - FSM, two states:
//     IDLE:  if |req, pick winner w = first set bit searching last+1, last+2, ... mod NUM_REQ.
//            Latch w, req_addr[w], req_data[w] and contended=(popcount(req)>1); go to WRITE.
//            Otherwise stay in IDLE.
//     WRITE: busy=1, grant[w]=1 (registered outputs, valid this whole cycle).
//            Write enable to bank[addr_latched] for this cycle; register loads at the closing edge.
//            last=w; unconditionally return to IDLE.
//   - Latency: req seen in IDLE at cycle T -> grant high in T+1.
//     The new value appears on rd_data from T+2. Peak throughput is 1 write per 2 cycles.
//   - Requester contract: hold req/addr/data stable until grant is seen; drop req the cycle after grant.
//     Addr/data are sampled at the IDLE->WRITE edge only.
//     Changes to req/addr/data during WRITE are ignored.
//   - Non-winning requests are not lost; they persist and compete at the next IDLE.
//     Rotation guarantees each active requester a grant within NUM_REQ arbitrations.
//   - Unselected bank registers hold their value; only one register is written per WRITE.
//   - rd_addr==addr_latched during WRITE returns the OLD value (no bypass).
//   - reset asserted mid-WRITE: write aborted (bank clears anyway), grant drops immediately, IDLE.
//   - req deasserted after the IDLE sample: write still completes (already committed).
// TESTING
//   1 reset: drive reset=0 with req=4'b1111 -> grant=0, busy=0, rd_data=0 for every rd_addr.
//   2 single write: req=0001, addr0=2, data0=3'b101 at T -> grant=0001 at T+1.
//     Then rd_addr=2 gives 3'b101 at T+2; other registers remain 0.
//   3 round-robin: req=1111 held, each dropping after its grant -> grant order 0,1,2,3.
//     One grant every 2 cycles; contended=1 on the first three grants, 0 on the last.
//   4 fairness wrap: after grant to 3, req=1001 -> grant 0 next; then 3 (req kept) -> grant 3.
//   5 same-register collision: req0 writes addr1=3'b011, then req1 writes addr1=3'b110 ->
//     rd_data(addr1)=011 after first grant, 110 after second; read during WRITE shows prior value.
//   6 reset mid-op: assert reset=0 during WRITE cycle -> grant falls asynchronously.
//     Bank reads 0; after release with req=0 the FSM stays IDLE with busy=0.

Source files
------------

// File: rtl/reg_bank_write_arbiter_if.sv
// Requester-side bus of the register-bank write arbiter: packed write requests,
// the one-hot grant and status flags, and the combinational read port.
interface reg_bank_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 2
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          contended;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0]         rd_data;

  // The requesters and the downstream reader sit on the master side.
  modport master (
    output req, req_addr, req_data, rd_addr,
    input  grant, busy, contended, rd_data
  );

  modport slave (
    input  req, req_addr, req_data, rd_addr,
    output grant, busy, contended, rd_data
  );

endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter feeding a small bank of enable-gated registers.
// One request is accepted per IDLE cycle, written during the following WRITE cycle.
module reg_bank_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  reg_bank_write_arbiter_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int IDX_W    = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  state_t                  state_q, state_d;
  idx_t                    last_q, last_d;
  idx_t                    win_q, win_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    contended_q, contended_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    bank_we;
  logic [DATA_WIDTH-1:0]   bank_q [NUM_REGS];

  idx_t                    rr_winner;
  logic                    rr_found;
  logic                    rr_multi;

  // Rotating search starting just after the last winner.
  always_comb begin
    int   cand;
    idx_t cand_idx;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    rr_found  = 1'b0;
    rr_winner = last_q;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = idx_t'(cand);
      if (!rr_found && bus.req[cand_idx]) begin
        rr_found  = 1'b1;
        rr_winner = cand_idx;
      end
    end
    rr_multi = ($countones(bus.req) > 1);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    addr_d      = addr_q;
    data_d      = data_q;
    contended_d = 1'b0;
    busy_d      = 1'b0;
    grant_d     = '0;
    bank_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d            = WRITE;
          win_d              = rr_winner;
          addr_d             = bus.req_addr[int'(rr_winner)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d             = bus.req_data[int'(rr_winner)*DATA_WIDTH +: DATA_WIDTH];
          contended_d        = rr_multi;
          busy_d             = 1'b1;
          grant_d[rr_winner] = 1'b1;
        end
      end
      WRITE: begin
        // The load lands at the edge closing this cycle, so reads see the old value until then.
        state_d = IDLE;
        last_d  = win_q;
        bank_we = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= idx_t'(NUM_REQ - 1);
      win_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      contended_q <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      contended_q <= contended_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
    end
  end

  // NOTE: the bank is a handful of flops with an architectural clear, so it is
  // reset like any other register rather than treated as an unreset RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        bank_q[r] <= '0;
      end
    end else if (bank_we) begin
      bank_q[addr_q] <= data_q;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.contended = contended_q;
  assign bus.rd_data   = bank_q[bus.rd_addr];

endmodule
